alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Upstream stage of the ALU: captures operand A, operand B and the opcode from a shared
//  switch bus on three successive load-button presses, then drives the ALU enable.
//  Registers the ALU result and flags when o_ready returns and holds them for display.
//  Times out to an error state if the ALU never reports ready (unsupported opcode).
// PARAMETERS
//  DW_IN      5   operand width; matches ALU DW_IN
//  DW_OUT     8   result width; matches ALU DW_OUT
//  NO         4   opcode width; matches ALU control width
//  TIMEOUT    15  max EXEC cycles waiting for i_ready before ERROR (>=1)
//  DB_CYCLES  16  stable cycles required to accept a press (ALU_SEQ_DEBOUNCE_EN only)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  i_switches   in   DW_IN   shared data bus for A, B, opcode (opcode = i_switches[NO-1:0])
//  i_load       in   1       asynchronous load button, active-high
//  i_clear      in   1       synchronous abort, active-high, returns to LOAD_A
//  i_result     in   DW_OUT  ALU o_result
//  i_ready      in   1       ALU o_ready
//  i_flags      in   4       ALU {o_zero,o_overflow,o_carry,o_negative}
//  o_numberA    out  DW_IN   registered operand A to ALU i_numberA
//  o_numberB    out  DW_IN   registered operand B to ALU i_numberB
//  o_control    out  NO      registered opcode to ALU control
//  o_enable     out  1       ALU enable; high only in EXEC
//  o_result     out  DW_OUT  captured result
//  o_flags      out  4       captured flags, same order as i_flags
//  o_done       out  1       high in DONE
//  o_error      out  1       high in ERROR
//  o_state      out  3       current state encoding
// BEHAVIOUR
//  Reset: all outputs 0, state LOAD_A. rst has priority over everything; reset mid-EXEC
//   drops o_enable the following cycle and discards the operation.
//  Press detection: i_load -> 2-flop sync (s1,s2) -> s3; load_p = s2 & ~s3 (one cycle).
//   i_load rising before edge 0 => capture at edge 2. Held button yields one pulse.
//  States (o_state): LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, DONE=4, ERROR=5.
//   LOAD_A : load_p -> o_numberA<=i_switches; -> LOAD_B
//   LOAD_B : load_p -> o_numberB<=i_switches; -> LOAD_OP
//   LOAD_OP: load_p -> o_control<=i_switches[NO-1:0]; tcnt<=0; -> EXEC
//   EXEC   : o_enable=1 (Moore, from state). i_ready=1 -> o_result<=i_result,
//            o_flags<=i_flags; -> DONE. Else tcnt++; tcnt==TIMEOUT-1 -> ERROR.
//            Valid opcode (0..9): ALU is combinational, so EXEC lasts exactly 1 cycle.
//   DONE   : hold result/flags/operands. load_p -> o_numberA<=i_switches; -> LOAD_B
//            (new sequence; o_result/o_flags held until next capture; o_done drops).
//   ERROR  : o_result, o_flags unchanged from last good capture. load_p -> LOAD_A.
//  load_p in EXEC ignored, not queued.
//  i_clear (sync, not synchronised internally): -> LOAD_A, clears o_numberA/B, o_control,
//   o_result, o_flags; wins over a simultaneous load_p or i_ready.
//  Operands/opcode are registers: stable for the whole EXEC cycle; no width conversion.
//  tcnt width = $clog2(TIMEOUT+1); never wraps (leaves EXEC at terminal count).
// CONFIGURATION
//  ALU_SEQ_DEBOUNCE_EN defined: s2 must remain constant for DB_CYCLES consecutive cycles
//   before the debounced level updates; load_p = rising edge of debounced level, so
//   capture latency = 2 + DB_CYCLES + 1 edges; glitches shorter than DB_CYCLES ignored.
//  Undefined: sync + edge detect only (latency above); DB_CYCLES unused.
// TESTING
//  1 Reset, switches 5'd3 press, 5'd4 press, 5'd0 press; ALU stub ready=1 result=8'd7
//    -> o_enable high 1 cycle, DONE, o_result=7, o_flags=0, o_state=4.
//  2 A=5'b11110(-2), B=5'd3, op=3; stub returns -6 -> o_result=8'hFA, negative flag=1.
//  3 op=4'd12, stub ready=0 -> o_enable high 15 cycles, then ERROR, o_error=1,
//    o_result holds prior value; next press -> LOAD_A, o_state=0.
//  4 i_load held high 50 cycles in LOAD_A -> only A captured, state LOAD_B.
//  5 i_clear and load_p same cycle in LOAD_OP -> LOAD_A, o_numberA/B/o_control=0;
//    rst asserted during EXEC -> next cycle o_enable=0, all outputs 0.
//  6 ALU_SEQ_DEBOUNCE_EN: 5-cycle i_load glitch -> no capture; 40-cycle press -> capture
//    at edge 2+16+1 after rise.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// ALU-facing bus of the operand sequencer: operands/opcode/enable out, result/ready/flags back.
interface alu_operand_sequencer_if #(
    parameter int unsigned DW_IN  = 5,
    parameter int unsigned DW_OUT = 8,
    parameter int unsigned NO     = 4
);
    logic [DW_IN-1:0]  o_numberA;
    logic [DW_IN-1:0]  o_numberB;
    logic [NO-1:0]     o_control;
    logic              o_enable;
    logic [DW_OUT-1:0] i_result;
    logic              i_ready;
    logic [3:0]        i_flags;

    // Sequencer side: drives operands and enable, observes the ALU response.
    modport master (
        output o_numberA,
        output o_numberB,
        output o_control,
        output o_enable,
        input  i_result,
        input  i_ready,
        input  i_flags
    );

    // ALU side.
    modport slave (
        input  o_numberA,
        input  o_numberB,
        input  o_control,
        input  o_enable,
        output i_result,
        output i_ready,
        output i_flags
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// ALU operand sequencer: captures A, B and opcode from a shared switch bus on three
// load presses, enables the ALU, captures result/flags or times out to ERROR.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN (adds a stable-level debouncer on i_load).
module alu_operand_sequencer #(
    parameter int unsigned DW_IN     = 5,
    parameter int unsigned DW_OUT    = 8,
    parameter int unsigned NO        = 4,
    parameter int unsigned TIMEOUT   = 15
`ifdef ALU_SEQ_DEBOUNCE_EN
    ,
    parameter int unsigned DB_CYCLES = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW_IN-1:0]        i_switches,
    input  logic                    i_load,
    input  logic                    i_clear,
    alu_operand_sequencer_if.master alu,
    output logic [DW_OUT-1:0]       o_result,
    output logic [3:0]              o_flags,
    output logic                    o_done,
    output logic                    o_error,
    output logic [2:0]              o_state
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [DW_IN-1:0]  numa_q, numa_d;
    logic [DW_IN-1:0]  numb_q, numb_d;
    logic [NO-1:0]     ctl_q, ctl_d;
    logic [DW_OUT-1:0] res_q, res_d;
    logic [3:0]        flg_q, flg_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic s1_q, s2_q, s3_q;
    logic load_p;

    // Two-flop synchroniser for the asynchronous button plus one delay stage for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= i_load;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [DBW-1:0] db_cnt_q;
    logic           db_lvl_q;
    logic           db_lvl_prev_q;

    // Debounced level follows s2 only after it has held one value for DB_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q      <= '0;
            db_lvl_q      <= 1'b0;
            db_lvl_prev_q <= 1'b0;
        end else begin
            db_lvl_prev_q <= db_lvl_q;
            if (s2_q != s3_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q != DB_LAST) begin
                db_cnt_q <= db_cnt_q + DBW'(1);
            end else begin
                db_lvl_q <= s2_q;
            end
        end
    end

    assign load_p = db_lvl_q & ~db_lvl_prev_q;
`else
    assign load_p = s2_q & ~s3_q;
`endif

    // Next-state and datapath update; clear overrides any press or ALU response.
    always_comb begin
        state_d = state_q;
        numa_d  = numa_q;
        numb_d  = numb_q;
        ctl_d   = ctl_q;
        res_d   = res_q;
        flg_d   = flg_q;
        tcnt_d  = tcnt_q;

        if (i_clear) begin
            state_d = S_LOAD_A;
            numa_d  = '0;
            numb_d  = '0;
            ctl_d   = '0;
            res_d   = '0;
            flg_d   = '0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (load_p) begin
                        numa_d  = i_switches;
                        state_d = S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (load_p) begin
                        numb_d  = i_switches;
                        state_d = S_LOAD_OP;
                    end
                end
                S_LOAD_OP: begin
                    if (load_p) begin
                        ctl_d   = i_switches[NO-1:0];
                        tcnt_d  = '0;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Presses here are dropped; only ready or terminal count leave EXEC.
                    if (alu.i_ready) begin
                        res_d   = alu.i_result;
                        flg_d   = alu.i_flags;
                        state_d = S_DONE;
                    end else if (tcnt_q == TCNT_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                S_DONE: begin
                    // A press here starts the next sequence by capturing operand A.
                    if (load_p) begin
                        numa_d  = i_switches;
                        state_d = S_LOAD_B;
                    end
                end
                S_ERROR: begin
                    if (load_p) begin
                        state_d = S_LOAD_A;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end

        en_d   = (state_d == S_EXEC);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
    end

    // State and datapath registers; reset has priority over clear and presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD_A;
            numa_q  <= '0;
            numb_q  <= '0;
            ctl_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            tcnt_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            numa_q  <= numa_d;
            numb_q  <= numb_d;
            ctl_q   <= ctl_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            tcnt_q  <= tcnt_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign alu.o_numberA = numa_q;
    assign alu.o_numberB = numb_q;
    assign alu.o_control = ctl_q;
    assign alu.o_enable  = en_q;
    assign o_result      = res_q;
    assign o_flags       = flg_q;
    assign o_done        = done_q;
    assign o_error       = err_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed press sequences against a behavioural model.
module tb_alu_operand_sequencer;

    localparam int unsigned DW_IN   = 5;
    localparam int unsigned DW_OUT  = 8;
    localparam int unsigned NO      = 4;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW_IN-1:0]  i_switches;
    logic              i_load;
    logic              i_clear;
    logic [DW_OUT-1:0] o_result;
    logic [3:0]        o_flags;
    logic              o_done;
    logic              o_error;
    logic [2:0]        o_state;

    int checks   = 0;
    int failures = 0;
    int en_cycles = 0;
    int e0;

    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.DW_IN(DW_IN), .DW_OUT(DW_OUT), .NO(NO)) alu_if ();

    alu_operand_sequencer #(
        .DW_IN(DW_IN), .DW_OUT(DW_OUT), .NO(NO), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_switches(i_switches),
        .i_load(i_load),
        .i_clear(i_clear),
        .alu(alu_if),
        .o_result(o_result),
        .o_flags(o_flags),
        .o_done(o_done),
        .o_error(o_error),
        .o_state(o_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Count cycles in which the ALU enable is seen high.
    always @(negedge clk) begin
        if (alu_if.o_enable === 1'b1) en_cycles++;
    end

`ifndef ALU_SEQ_DEBOUNCE_EN
    // Model: a press is seen when i_load sampled two edges ago is 1 and three edges ago is 0.
    int         m_st;
    int         m_wait;
    logic [4:0] m_a, m_b;
    logic [3:0] m_ctl;
    logic [7:0] m_res;
    logic [3:0] m_fl;
    logic       h1, h2, h3;
    logic       lp;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        lp = h2 & ~h3;
        h3 = h2;
        h2 = h1;
        h1 = i_load;
        if (rst) begin
            m_valid = 1'b1;
            m_st = 0; m_wait = 0;
            m_a = '0; m_b = '0; m_ctl = '0; m_res = '0; m_fl = '0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else if (i_clear) begin
            m_st = 0;
            m_a = '0; m_b = '0; m_ctl = '0; m_res = '0; m_fl = '0;
        end else begin
            case (m_st)
                0: if (lp) begin m_a = i_switches; m_st = 1; end
                1: if (lp) begin m_b = i_switches; m_st = 2; end
                2: if (lp) begin m_ctl = i_switches[3:0]; m_wait = 0; m_st = 3; end
                3: begin
                    if (alu_if.i_ready) begin
                        m_res = alu_if.i_result;
                        m_fl  = alu_if.i_flags;
                        m_st  = 4;
                    end else begin
                        m_wait++;
                        if (m_wait == int'(TIMEOUT)) m_st = 5;
                    end
                end
                4: if (lp) begin m_a = i_switches; m_st = 1; end
                5: if (lp) m_st = 0;
                default: m_st = 0;
            endcase
        end
    end

    // Compare every DUT output against the model on each falling edge once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",   32'(o_state),          32'(m_st));
            chk("numberA", 32'(alu_if.o_numberA), 32'(m_a));
            chk("numberB", 32'(alu_if.o_numberB), 32'(m_b));
            chk("control", 32'(alu_if.o_control), 32'(m_ctl));
            chk("enable",  32'(alu_if.o_enable),  32'(m_st == 3));
            chk("result",  32'(o_result),         32'(m_res));
            chk("flags",   32'(o_flags),          32'(m_fl));
            chk("done",    32'(o_done),           32'(m_st == 4));
            chk("error",   32'(o_error),          32'(m_st == 5));
        end
    end
`endif

    // Raise i_load with the given switch value, hold it, release, then idle a few cycles.
    task automatic press(input logic [4:0] sw, input int hold);
        i_switches = sw;
        i_load     = 1'b1;
        repeat (hold) @(posedge clk);
        #1 i_load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic stub(input logic rdy, input logic [7:0] res, input logic [3:0] fl);
        alu_if.i_ready  = rdy;
        alu_if.i_result = res;
        alu_if.i_flags  = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_load = 1'b0; i_clear = 1'b0; i_switches = '0;
        stub(1'b0, 8'h00, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   32'(o_state),          32'd0);
        chk("rst_enable",  32'(alu_if.o_enable),  32'd0);
        chk("rst_numberA", 32'(alu_if.o_numberA), 32'd0);
        chk("rst_result",  32'(o_result),         32'd0);
        chk("rst_done",    32'(o_done),           32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

`ifdef ALU_SEQ_DEBOUNCE_EN
        // Short glitch is filtered out.
        i_switches = 5'd7;
        i_load = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_load = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_state",   32'(o_state),          32'd0);
        chk("glitch_numberA", 32'(alu_if.o_numberA), 32'd0);
        // Long press captures 2 + 16 + 1 edges after the rise.
        i_switches = 5'd9;
        i_load = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        chk("db_pre_state", 32'(o_state), 32'd0);
        @(posedge clk);
        #1;
        chk("db_cap_state",   32'(o_state),          32'd1);
        chk("db_cap_numberA", 32'(alu_if.o_numberA), 32'd9);
        repeat (20) @(posedge clk);
        #1 i_load = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("db_hold_state", 32'(o_state), 32'd1);
`else
        // 3 + 4 with opcode 0, stub answers 7 immediately.
        stub(1'b1, 8'd7, 4'h0);
        e0 = en_cycles;
        press(5'd3, 3);
        press(5'd4, 3);
        press(5'd0, 3);
        chk("t1_en_cycles", 32'(en_cycles - e0),    32'd1);
        chk("t1_state",     32'(o_state),           32'd4);
        chk("t1_result",    32'(o_result),          32'd7);
        chk("t1_flags",     32'(o_flags),           32'd0);
        chk("t1_done",      32'(o_done),            32'd1);
        chk("t1_numberB",   32'(alu_if.o_numberB),  32'd4);

        // -2 * 3 -> -6 with negative flag; sequence restarts from DONE.
        stub(1'b1, 8'hFA, 4'b0001);
        press(5'b11110, 3);
        press(5'd3, 3);
        press(5'd3, 3);
        chk("t2_result",   32'(o_result),          32'hFA);
        chk("t2_negative", 32'(o_flags[0]),        32'd1);
        chk("t2_numberA",  32'(alu_if.o_numberA),  32'h1E);
        chk("t2_state",    32'(o_state),           32'd4);

        // Unsupported opcode: ALU never ready -> 15 enable cycles then ERROR.
        stub(1'b0, 8'h55, 4'hF);
        e0 = en_cycles;
        press(5'd1, 3);
        press(5'd2, 3);
        press(5'd12, 3);
        repeat (25) @(posedge clk);
        #1;
        chk("t3_en_cycles", 32'(en_cycles - e0),   32'd15);
        chk("t3_error",     32'(o_error),          32'd1);
        chk("t3_state",     32'(o_state),          32'd5);
        chk("t3_result",    32'(o_result),         32'hFA);
        chk("t3_control",   32'(alu_if.o_control), 32'd12);
        press(5'd0, 3);
        chk("t3_back_state", 32'(o_state), 32'd0);

        // Button held for 50 cycles yields a single capture.
        press(5'd9, 50);
        chk("t4_state",   32'(o_state),          32'd1);
        chk("t4_numberA", 32'(alu_if.o_numberA), 32'd9);

        // Clear coincident with the opcode press wins.
        press(5'd6, 3);
        chk("t5_pre_state", 32'(o_state), 32'd2);
        i_switches = 5'd5;
        i_load = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 i_clear = 1'b1;
        @(posedge clk);
        #1 i_clear = 1'b0;
        chk("t5_clr_state",   32'(o_state),          32'd0);
        chk("t5_clr_numberA", 32'(alu_if.o_numberA), 32'd0);
        chk("t5_clr_numberB", 32'(alu_if.o_numberB), 32'd0);
        chk("t5_clr_control", 32'(alu_if.o_control), 32'd0);
        chk("t5_clr_result",  32'(o_result),         32'd0);
        repeat (3) @(posedge clk);
        #1 i_load = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_no_late_press", 32'(o_state), 32'd0);

        // Reset while in EXEC drops enable on the next cycle.
        stub(1'b0, 8'h00, 4'h0);
        press(5'd1, 3);
        press(5'd2, 3);
        press(5'd3, 3);
        chk("t5_exec_enable", 32'(alu_if.o_enable), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_enable",  32'(alu_if.o_enable),  32'd0);
        chk("t5_rst_state",   32'(o_state),          32'd0);
        chk("t5_rst_numberA", 32'(alu_if.o_numberA), 32'd0);
        chk("t5_rst_control", 32'(alu_if.o_control), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
